// File: rtl/fixed_conv_arbiter_if.sv
// ---------------------------------------------------------------------------
// fixed_conv_arbiter_if
// Bundles the streams around the float-to-fixed converter arbiter.
//   req_*          : NUM_REQ requester operand streams (packed, channel i at
//                    bits [i*SIZE +: SIZE])
//   resp_*         : result stream, data broadcast, valid one-hot per channel
//   conv_a_*       : shared converter input stream
//   conv_result_*  : converter result stream
// Modports:
//   slave  : arbiter view
//   master : environment view (requesters + converter)
// ---------------------------------------------------------------------------
interface fixed_conv_arbiter_if #(
    parameter int SIZE    = 32,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ*SIZE-1:0] req_tdata;
    logic [NUM_REQ-1:0]      req_tvalid;
    logic [NUM_REQ-1:0]      req_tready;

    logic [SIZE-1:0]         resp_tdata;
    logic [NUM_REQ-1:0]      resp_tvalid;
    logic [NUM_REQ-1:0]      resp_tready;

    logic [SIZE-1:0]         conv_a_tdata;
    logic                    conv_a_tvalid;
    logic                    conv_a_tready;

    logic [SIZE-1:0]         conv_result_tdata;
    logic                    conv_result_tvalid;
    logic                    conv_result_tready;

    modport slave (
        input  req_tdata, req_tvalid,
        output req_tready,
        output resp_tdata, resp_tvalid,
        input  resp_tready,
        output conv_a_tdata, conv_a_tvalid,
        input  conv_a_tready,
        input  conv_result_tdata, conv_result_tvalid,
        output conv_result_tready
    );

    modport master (
        output req_tdata, req_tvalid,
        input  req_tready,
        input  resp_tdata, resp_tvalid,
        output resp_tready,
        input  conv_a_tdata, conv_a_tvalid,
        output conv_a_tready,
        output conv_result_tdata, conv_result_tvalid,
        input  conv_result_tready
    );
endinterface

// File: rtl/fixed_conv_arbiter.sv
// ---------------------------------------------------------------------------
// fixed_conv_arbiter
// Shares one float-to-fixed converter between NUM_REQ requesters. Requests
// are granted round-robin with zero added latency; the granted channel index
// is pushed into a tag FIFO on issue, and converter results are routed back
// to the channel at the FIFO head, strictly in issue order.
// Ports:
//   aclk        : clock, rising edge
//   aresetn     : asynchronous active-low reset
//   bus         : fixed_conv_arbiter_if.slave (request/response/converter)
//   inflight    : tag FIFO occupancy (issued, unreturned conversions)
//   err_orphan  : sticky, a result arrived with no outstanding tag
// ---------------------------------------------------------------------------
module fixed_conv_arbiter #(
    parameter int SIZE         = 32,
    parameter int NUM_REQ      = 4,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    fixed_conv_arbiter_if.slave           bus,
    output logic [$clog2(MAX_INFLIGHT):0] inflight,
    output logic                          err_orphan
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_INFLIGHT);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] r_rr_ptr;
    logic             r_lock_vld;
    logic [IDX_W-1:0] r_lock_idx;
    logic [IDX_W-1:0] r_tag_mem [MAX_INFLIGHT];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_err_orphan;

    logic             w_full;
    logic             w_empty;
    logic             w_any_req;
    logic             w_grant_vld;
    logic [IDX_W-1:0] w_grant;
    logic [IDX_W-1:0] w_cand;
    logic             w_issue;
    logic             w_pop;
    logic [IDX_W-1:0] w_head;

    // Full/empty come from registered occupancy, so a pop in the same cycle
    // never opens a slot for a push.
    assign w_full    = (r_count == CNT_W'(MAX_INFLIGHT));
    assign w_empty   = (r_count == '0);
    assign w_any_req = |bus.req_tvalid;

    // Grant: a channel that was offered but not accepted keeps the grant while
    // it holds tvalid; otherwise search upward from rr_ptr.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_cand      = '0;
        if (r_lock_vld && bus.req_tvalid[r_lock_idx]) begin
            w_grant_vld = 1'b1;
            w_grant     = r_lock_idx;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_cand = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
                if (!w_grant_vld && bus.req_tvalid[w_cand]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = w_cand;
                end
            end
        end
    end

    // Request path: operand mux and per-channel ready.
    always_comb begin
        bus.conv_a_tdata = '0;
        bus.req_tready   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_vld && (w_grant == IDX_W'(i))) begin
                bus.conv_a_tdata  = bus.req_tdata[i*SIZE +: SIZE];
                bus.req_tready[i] = bus.conv_a_tready && !w_full;
            end
        end
    end

    assign bus.conv_a_tvalid = w_any_req && !w_full;
    assign w_issue           = bus.conv_a_tvalid && bus.conv_a_tready;

    // Result path: route to the owner at the FIFO head; with no tag
    // outstanding the result is accepted and dropped.
    assign w_head = r_tag_mem[r_rd_ptr];

    always_comb begin
        bus.resp_tvalid        = '0;
        bus.conv_result_tready = 1'b1;
        if (!w_empty) begin
            bus.conv_result_tready = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_head == IDX_W'(i)) begin
                    bus.resp_tvalid[i]     = bus.conv_result_tvalid;
                    bus.conv_result_tready = bus.resp_tready[i];
                end
            end
        end
    end

    assign bus.resp_tdata = bus.conv_result_tdata;
    assign w_pop          = !w_empty && bus.conv_result_tvalid && bus.conv_result_tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rr_ptr     <= '0;
            r_lock_vld   <= 1'b0;
            r_lock_idx   <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_issue) begin
                r_rr_ptr <= (w_grant == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant + IDX_W'(1);
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_lock_vld <= w_grant_vld && !w_issue;
            r_lock_idx <= w_grant;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_issue, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_empty && bus.conv_result_tvalid) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    // Tag storage holds data only; validity is tracked by r_count.
    always_ff @(posedge aclk) begin
        if (w_issue) begin
            r_tag_mem[r_wr_ptr] <= w_grant;
        end
    end

    assign inflight   = r_count;
    assign err_orphan = r_err_orphan;
endmodule

// File: tb/tb_fixed_conv_arbiter.sv
`timescale 1ns/1ps
module tb_fixed_conv_arbiter;
    localparam int SIZE = 32;
    localparam int NREQ = 4;
    localparam int MAXI = 8;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic [3:0] inflight;
    logic       err_orphan;

    int tests = 0;
    int fails = 0;

    // Reference model: round-robin pointer, held-grant channel, tag queue.
    int  m_rr;
    int  m_lock;
    int  tags[$];
    bit  m_orphan;
    int  last_issue;
    logic [3:0] g_rv;
    logic       g_ctr;
    logic [31:0] g_rd;

    bit          pend [NREQ];
    logic [31:0] word [NREQ];

    fixed_conv_arbiter_if #(.SIZE(SIZE), .NUM_REQ(NREQ)) bus ();

    fixed_conv_arbiter #(.SIZE(SIZE), .NUM_REQ(NREQ), .MAX_INFLIGHT(MAXI)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .bus        (bus),
        .inflight   (inflight),
        .err_orphan (err_orphan)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0;
        m_lock = -1;
        tags.delete();
        m_orphan = 0;
        last_issue = -1;
    endtask

    task automatic set_req(input int ch, input logic v, input logic [31:0] d);
        bus.req_tvalid[ch] = v;
        bus.req_tdata[ch*SIZE +: SIZE] = d;
    endtask

    // Called at posedge+1 with inputs already driven; checks all outputs
    // mid-cycle, advances the model, returns at the next posedge+1.
    task automatic step();
        int g;
        bit full, empty, exp_av, exp_ctr, issue, pop;
        logic [3:0]  exp_rdy, exp_rv;
        logic [31:0] exp_ad;
        #3;
        g = -1;
        if (m_lock >= 0 && bus.req_tvalid[m_lock]) g = m_lock;
        else begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_rr + k) % NREQ;
                if (g < 0 && bus.req_tvalid[c]) g = c;
            end
        end
        full   = (tags.size() == MAXI);
        empty  = (tags.size() == 0);
        exp_av = (bus.req_tvalid != 0) && !full;
        exp_ad = (g >= 0) ? bus.req_tdata[g*SIZE +: SIZE] : 32'h0;
        exp_rdy = (g >= 0 && bus.conv_a_tready && !full) ? (4'b1 << g) : 4'b0;
        if (empty) begin
            exp_rv  = 4'b0;
            exp_ctr = 1'b1;
        end else begin
            exp_rv  = bus.conv_result_tvalid ? (4'b1 << tags[0]) : 4'b0;
            exp_ctr = bus.resp_tready[tags[0]];
        end
        chk("conv_a_tvalid", bus.conv_a_tvalid, exp_av);
        chk("conv_a_tdata", bus.conv_a_tdata, exp_ad);
        chk("req_tready", bus.req_tready, exp_rdy);
        chk("resp_tvalid", bus.resp_tvalid, exp_rv);
        chk("resp_tdata", bus.resp_tdata, bus.conv_result_tdata);
        chk("conv_result_tready", bus.conv_result_tready, exp_ctr);
        chk("inflight", inflight, tags.size());
        chk("err_orphan", err_orphan, m_orphan);
        g_rv  = bus.resp_tvalid;
        g_ctr = bus.conv_result_tready;
        g_rd  = bus.resp_tdata;
        issue = exp_av && bus.conv_a_tready;
        pop   = !empty && bus.conv_result_tvalid && exp_ctr;
        if (empty && bus.conv_result_tvalid) m_orphan = 1;
        if (pop) void'(tags.pop_front());
        if (issue) begin
            tags.push_back(g);
            m_rr = (g + 1) % NREQ;
            m_lock = -1;
            last_issue = g;
        end else begin
            m_lock = g;
            last_issue = -1;
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_tvalid = '0;
        bus.req_tdata = '0;
        bus.conv_a_tready = 1'b0;
        bus.conv_result_tvalid = 1'b0;
        bus.conv_result_tdata = '0;
        bus.resp_tready = '0;
    endtask

    task automatic sync_reset();
        aresetn = 1'b0;
        model_reset();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic drain();
        bus.req_tvalid = '0;
        bus.resp_tready = 4'hF;
        for (int n = 0; n < 2*MAXI && tags.size() > 0; n++) begin
            bus.conv_result_tvalid = 1'b1;
            bus.conv_result_tdata = $urandom;
            step();
        end
        chk("drain_done", tags.size(), 0);
        bus.conv_result_tvalid = 1'b0;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        #3;
        chk("rst_inflight", inflight, 4'd0);
        chk("rst_orphan", err_orphan, 1'b0);
        chk("rst_resp_tvalid", bus.resp_tvalid, 4'b0);
        chk("rst_conv_a_tvalid", bus.conv_a_tvalid, 1'b0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // All four requesting, converter always ready: 0,1,2,3,0,... until full.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 32'h1000_0000 * (i + 1) + i);
        bus.conv_a_tready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("rr_order", last_issue, (k < MAXI) ? (k % NREQ) : -1);
        end
        chk("full_inflight", inflight, 4'd8);

        // Full with a same-cycle pop: no issue this cycle, issue the next.
        bus.resp_tready = 4'hF;
        bus.conv_result_tvalid = 1'b1;
        bus.conv_result_tdata = 32'h0000_1234;
        step();
        chk("full_pop_no_issue", last_issue, -1);
        chk("full_pop_inflight", inflight, 4'd7);
        bus.conv_result_tvalid = 1'b0;
        step();
        chk("full_next_issue", last_issue, 0);
        drain();

        // Orphan result, then reset with conversions outstanding.
        bus.conv_result_tvalid = 1'b1;
        bus.conv_result_tdata = 32'hDEAD_BEEF;
        step();
        bus.conv_result_tvalid = 1'b0;
        step();
        chk("orphan_set", err_orphan, 1'b1);
        step();
        chk("orphan_sticky", err_orphan, 1'b1);
        set_req(0, 1'b1, 32'h3F80_0000);
        for (int k = 0; k < 5; k++) step();
        chk("pre_rst_inflight", inflight, 4'd5);
        clear_inputs();
        aresetn = 1'b0;
        #1;
        chk("async_rst_inflight", inflight, 4'd0);
        chk("async_rst_orphan", err_orphan, 1'b0);
        chk("async_rst_resp_tvalid", bus.resp_tvalid, 4'b0);
        model_reset();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // Pointer at 2 with channels 1 and 3 valid: 3 wins, then 1.
        bus.conv_a_tready = 1'b1;
        set_req(1, 1'b1, 32'h0000_0011);
        step();
        chk("rr_setup", last_issue, 1);
        set_req(1, 1'b1, 32'h0000_0021);
        set_req(3, 1'b1, 32'h0000_0023);
        step();
        chk("rr_ptr2_first", last_issue, 3);
        set_req(3, 1'b0, 32'h0);
        step();
        chk("rr_ptr2_second", last_issue, 1);
        drain();

        // In-order return with the reference words.
        sync_reset();
        bus.conv_a_tready = 1'b1;
        set_req(2, 1'b1, 32'h4049_0FDB);
        step();
        chk("iss_ch2", last_issue, 2);
        set_req(2, 1'b0, 32'h0);
        set_req(0, 1'b1, 32'hC000_0000);
        step();
        chk("iss_ch0", last_issue, 0);
        set_req(0, 1'b0, 32'h0);
        bus.resp_tready = 4'hF;
        bus.conv_result_tvalid = 1'b1;
        bus.conv_result_tdata = 32'h0000_0003;
        step();
        chk("ret0_valid", g_rv, 4'b0100);
        chk("ret0_data", g_rd, 32'h0000_0003);
        bus.conv_result_tdata = 32'hFFFF_FFFE;
        step();
        chk("ret1_valid", g_rv, 4'b0001);
        chk("ret1_data", g_rd, 32'hFFFF_FFFE);
        bus.conv_result_tvalid = 1'b0;

        // Owner backpressure holds the head tag.
        set_req(2, 1'b1, 32'h4120_0000);
        step();
        set_req(2, 1'b0, 32'h0);
        bus.conv_result_tvalid = 1'b1;
        bus.conv_result_tdata = 32'h0000_000A;
        bus.resp_tready = 4'b1011;
        step();
        chk("bp_ctready", g_ctr, 1'b0);
        step();
        chk("bp_hold_inflight", inflight, 4'd1);
        bus.resp_tready = 4'hF;
        step();
        chk("bp_release_ctready", g_ctr, 1'b1);
        chk("bp_release_inflight", inflight, 4'd0);
        bus.conv_result_tvalid = 1'b0;

        // Randomized traffic; requesters hold operands until accepted.
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 0;
            word[i] = '0;
        end
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    word[i] = $urandom;
                end
                set_req(i, pend[i], pend[i] ? word[i] : 32'h0);
            end
            bus.conv_a_tready = ($urandom_range(0, 3) != 0);
            bus.conv_result_tvalid = ($urandom_range(0, 2) == 0);
            bus.conv_result_tdata = $urandom;
            bus.resp_tready = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            step();
            if (last_issue >= 0) pend[last_issue] = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
